// File: rtl/median_pkg.sv
// Shared types for the median output path: default lane geometry,
// sequencer state encoding and the packed lane bundle.
package median_pkg;

    localparam int DEF_LANES  = 4;
    localparam int DEF_DATA_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Lane k occupies bits [k*DEF_DATA_W +: DEF_DATA_W]
    typedef logic [DEF_LANES-1:0][DEF_DATA_W-1:0] bundle_t;

endpackage

// File: rtl/median_bundle_fifo.sv
// DEPTH-entry bundle buffer with full/empty/count and a look-ahead port
// exposing the low PEEK_W bits of the entry that becomes head after a pop.
module median_bundle_fifo #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 2,
    parameter int PEEK_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           head_data,
    output logic [PEEK_W-1:0]          next_peek,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH-1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
    logic [CNT_W-1:0] count_reg;
    logic             do_wr, do_rd;

    // Explicit wrap so DEPTH need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_wr = wr_en && !full && !clear;
    assign do_rd = rd_en && !empty && !clear;

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_reg] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_rd) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_ptr_inc = ptr_inc(rd_ptr_reg);
    assign head_data  = mem[rd_ptr_reg];
    // With a single entry the successor is whatever is being written this cycle
    assign next_peek  = (count_reg > CNT_W'(1)) ? mem[rd_ptr_inc][PEEK_W-1:0]
                                                : wr_data[PEEK_W-1:0];
    assign full       = (count_reg == CNT_FULL);
    assign empty      = (count_reg == '0);
    assign count      = count_reg;

endmodule

// File: rtl/median_lane_sequencer.sv
// Serializes buffered lane bundles onto an AXI-stream pixel output,
// lane0 first, with tlast at each line end and a line-done pulse after it.
module median_lane_sequencer
    import median_pkg::*;
#(
    parameter int LANES       = DEF_LANES,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int LINE_PIXELS = 512,
    parameter int DEPTH       = 2
) (
    input  logic                    axi_clk,
    input  logic                    axi_reset_n,
    input  logic                    i_clear,
    input  logic                    i_lane_valid,
    input  logic [LANES*DATA_W-1:0] i_lane_data,
    output logic                    o_lane_ready,
    output logic [DATA_W-1:0]       o_data,
    output logic                    o_data_valid,
    input  logic                    i_data_ready,
    output logic                    o_last,
    output logic                    o_line_done,
    output logic                    o_busy
);

    localparam int LIDX_W = $clog2(LANES);
    localparam int PIX_W  = $clog2(LINE_PIXELS);
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam logic [LIDX_W-1:0] LANE_LAST = LIDX_W'(LANES-1);
    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(LINE_PIXELS-1);

    state_t              state_reg, state_next;
    logic [LIDX_W-1:0]   lane_idx_reg, lane_idx_next, lane_inc;
    logic [PIX_W-1:0]    pix_cnt_reg, pix_cnt_next;
    logic [DATA_W-1:0]   data_reg, data_next;
    logic                valid_reg, valid_next;
    logic                line_done_reg, line_done_next;

    logic [LANES*DATA_W-1:0] head_data;
    logic [DATA_W-1:0]       head_lane [LANES];
    logic [DATA_W-1:0]       next_lane0;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_full, fifo_empty;
    logic                    push, pop, beat_done, more;

    median_bundle_fifo #(
        .WIDTH  (LANES*DATA_W),
        .DEPTH  (DEPTH),
        .PEEK_W (DATA_W)
    ) u_fifo (
        .clk       (axi_clk),
        .rst_n     (axi_reset_n),
        .clear     (i_clear),
        .wr_en     (push),
        .wr_data   (i_lane_data),
        .rd_en     (pop),
        .head_data (head_data),
        .next_peek (next_lane0),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign head_lane[gi] = head_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign push      = i_lane_valid && !fifo_full && !i_clear;
    assign beat_done = valid_reg && i_data_ready;
    // Another bundle is available after the pop, including one arriving now
    assign more      = (fifo_count > CNT_W'(1)) || push;
    assign lane_inc  = lane_idx_reg + LIDX_W'(1);

    always_comb begin
        state_next     = state_reg;
        lane_idx_next  = lane_idx_reg;
        pix_cnt_next   = pix_cnt_reg;
        data_next      = data_reg;
        valid_next     = valid_reg;
        line_done_next = 1'b0;
        pop            = 1'b0;
        if (i_clear) begin
            state_next    = IDLE;
            lane_idx_next = '0;
            pix_cnt_next  = '0;
            valid_next    = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        data_next     = head_lane[0];
                        valid_next    = 1'b1;
                        lane_idx_next = '0;
                        state_next    = EMIT;
                    end
                end
                EMIT: begin
                    if (beat_done) begin
                        pix_cnt_next   = (pix_cnt_reg == PIX_LAST) ? '0 : pix_cnt_reg + PIX_W'(1);
                        line_done_next = (pix_cnt_reg == PIX_LAST);
                        if (lane_idx_reg == LANE_LAST) begin
                            pop           = 1'b1;
                            lane_idx_next = '0;
                            if (more) begin
                                data_next = next_lane0;
                            end else begin
                                valid_next = 1'b0;
                                state_next = IDLE;
                            end
                        end else begin
                            lane_idx_next = lane_inc;
                            data_next     = head_lane[lane_inc];
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_reg     <= IDLE;
            lane_idx_reg  <= '0;
            pix_cnt_reg   <= '0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            line_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            lane_idx_reg  <= lane_idx_next;
            pix_cnt_reg   <= pix_cnt_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            line_done_reg <= line_done_next;
        end
    end

    assign o_data       = data_reg;
    assign o_data_valid = valid_reg;
    assign o_last       = valid_reg && (pix_cnt_reg == PIX_LAST);
    assign o_line_done  = line_done_reg;
    assign o_lane_ready = !fifo_full;
    assign o_busy       = valid_reg || !fifo_empty;

endmodule
